// File: rtl/bitwise_accum_pkg.sv
// Typed views of the shared op and state encodings used by the accumulator.
`include "multi_bit_defs.vh"

package bitwise_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `BA_ST_IDLE,
    ST_ACC  = `BA_ST_ACC,
    ST_HOLD = `BA_ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    OP_AND  = `BA_OP_AND,
    OP_OR   = `BA_OP_OR,
    OP_XOR  = `BA_OP_XOR,
    OP_XNOR = `BA_OP_XNOR
  } op_e;

endpackage

// File: rtl/multi_bit_defs.vh
// Shared encodings for the bitwise accumulator: operation codes and FSM states.
`ifndef MULTI_BIT_DEFS_VH
`define MULTI_BIT_DEFS_VH

`define BA_OP_AND   2'b00
`define BA_OP_OR    2'b01
`define BA_OP_XOR   2'b10
`define BA_OP_XNOR  2'b11

`define BA_ST_IDLE  2'b00
`define BA_ST_ACC   2'b01
`define BA_ST_HOLD  2'b10

`endif

// File: rtl/or_gate.sv
// Two-input OR leaf used to build reduction trees.
module or_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i | b_i;

endmodule

// File: rtl/or_reduce_n.sv
// Balanced OR-reduction tree: splits the vector in halves recursively and
// joins the halves with or_gate leaves, giving log2(WIDTH) gate levels.
module or_reduce_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_i,
  output logic             out_o
);

  if (WIDTH == 1) begin : g_leaf
    assign out_o = in_i[0];
  end else if (WIDTH == 2) begin : g_pair
    or_gate u_or (
      .a_i (in_i[0]),
      .b_i (in_i[1]),
      .y_o (out_o)
    );
  end else begin : g_split
    localparam int LoW = WIDTH / 2;
    localparam int HiW = WIDTH - LoW;

    logic lo_y;
    logic hi_y;

    or_reduce_n #(.WIDTH(LoW)) u_lo (
      .in_i  (in_i[LoW-1:0]),
      .out_o (lo_y)
    );

    or_reduce_n #(.WIDTH(HiW)) u_hi (
      .in_i  (in_i[WIDTH-1:LoW]),
      .out_o (hi_y)
    );

    or_gate u_join (
      .a_i (lo_y),
      .b_i (hi_y),
      .y_o (out_o)
    );
  end

endmodule

// File: rtl/bitwise_accum.sv
// Frame-based bitwise accumulator: folds a stream of words with AND/OR/XOR/XNOR
// (op chosen on the first beat), ends a frame on in_last or at MAX_LEN beats,
// and holds the result until the consumer takes it.
module bitwise_accum
  import bitwise_accum_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic             out_zero,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    count_q;
  op_e              op_q;
  logic             trunc_q;

  logic             beat;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    count_d;
  op_e              op_d;
  logic             frame_end;

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign beat      = in_valid & in_ready;

  // Next accumulator/count/op for an accepted beat; the first beat loads
  // in_data as-is and latches op, later beats fold with the latched op.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc_d     = acc_q;
    count_d   = count_q;
    op_d      = op_q;
    frame_end = 1'b0;
    if (state_q == ST_IDLE) begin
      acc_d   = in_data;
      count_d = CW'(1);
      op_d    = op_e'(op);
    end else begin
      count_d = count_q + CW'(1);
      case (op_q)
        OP_AND:  acc_d = acc_q & in_data;
        OP_OR:   acc_d = acc_q | in_data;
        OP_XOR:  acc_d = acc_q ^ in_data;
        OP_XNOR: acc_d = ~(acc_q ^ in_data);
        default: acc_d = acc_q;
      endcase
    end
    frame_end = in_last | (count_d == CW'(MAX_LEN));
  end

  // Frame FSM with registered result fields; reset discards any open or
  // pending frame.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is an ordinary branch sampled on the
    // clock edge and is absent from the sensitivity list.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= OP_AND;
      trunc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (beat) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
            if (frame_end) begin
              state_q <= ST_HOLD;
              trunc_q <= ~in_last;
            end else begin
              state_q <= ST_ACC;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;

  or_reduce_n #(.WIDTH(WIDTH)) u_any (
    .in_i  (acc_q),
    .out_o (out_any)
  );

  assign out_zero = ~out_any;

endmodule

// File: doc/bitwise_accum.md
BITWISE_ACCUM -- requirements
Module: bitwise_accum

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be at least 2.
REQ-002 Parameter MAX_LEN, default 16, maximum beats per frame; SHALL be at least 1.
REQ-003 Derived constant CW = $clog2(MAX_LEN+1), width of the beat counter.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  1  input beat offered.
REQ-007 in_ready  output  1  block accepts an input beat.
REQ-008 in_data  input  WIDTH  operand word.
REQ-009 in_last  input  1  final beat of the frame.
REQ-010 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-011 out_valid  output  1  result held.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  WIDTH  accumulated result.
REQ-014 out_any  output  1  OR-reduction of out_data.
REQ-015 out_zero  output  1  out_any inverted.
REQ-016 out_count  output  CW  number of beats accepted in the frame.
REQ-017 out_trunc  output  1  frame ended by the MAX_LEN cap, not by in_last.

Function
REQ-018 A beat transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.
REQ-019 The FSM SHALL have three states: IDLE (no frame), ACC (frame open), HOLD (result pending).
REQ-020 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-021 IDLE, on an accepted beat: acc <= in_data, count <= 1, op latched.
REQ-022 The first beat SHALL load acc unchanged regardless of op.
REQ-023 ACC, on an accepted beat: acc <= acc op in_data using the latched op; count <= count+1.
REQ-024 op SHALL be ignored on all beats after the first; a mid-frame op change SHALL have no effect.
REQ-025 The state SHALL go to HOLD on an accepted beat with in_last=1, from IDLE or ACC; out_trunc <= 0.
REQ-026 The state SHALL go to HOLD on an accepted beat that makes count equal MAX_LEN with in_last=0; out_trunc <= 1.
REQ-027 With MAX_LEN=1, every frame is one beat and out_trunc equals ~in_last of that beat.
REQ-028 Latency: out_valid SHALL rise on the cycle after the final beat is accepted.
REQ-029 out_data, out_count, out_trunc, out_any and out_zero SHALL stay stable for the whole of HOLD.
REQ-030 HOLD SHALL go to IDLE on the cycle out_ready=1; the next beat can be accepted one cycle later.
REQ-031 out_any and out_zero SHALL be combinational from the registered out_data.
REQ-032 With no in_valid, the block SHALL stay in IDLE or ACC indefinitely with no state change.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL load: state IDLE, acc 0, count 0, out_trunc 0, latched op 00.
REQ-034 Reset outputs: out_valid 0, out_data 0, out_count 0, out_zero 1, out_any 0, in_ready 1.
REQ-035 Reset mid-frame or in HOLD SHALL discard the partial or pending result; no output transfer occurs.

Structure
REQ-036 The op encodings and FSM state encodings SHALL be `define constants in a shared header, multi_bit_defs.vh, behind an include guard.
REQ-037 The OR-reduction SHALL be one sub-module, or_reduce_n, parametrised by WIDTH and built as a balanced tree of or_gate instances.

Verification
REQ-038 The bench SHALL cover the following directed scenarios with WIDTH=16 and MAX_LEN=4 (MAX_LEN=16 where stated).
REQ-039 AND frame (MAX_LEN=16): 0xFF0F, 0x0FFF, 0x00FF(last) -> out_data 0x000F, count 3, any 1, zero 0, trunc 0, out_valid one cycle after the last beat.
REQ-040 XOR single beat: 0xA5A5 with last=1 -> out_data 0xA5A5, count 1; op changed to AND on a 2nd frame's beat 2 -> still XOR applied.
REQ-041 OR frame: 0x0000, 0x0000(last) -> out_data 0x0000, zero 1, any 0, count 2.
REQ-042 Truncation: 5 XNOR beats, none with last -> first 4 beats form a frame with trunc 1, count 4; the 5th beat waits (in_ready 0) and then starts a new frame.
REQ-043 Backpressure: out_ready held 0 for 3 cycles in HOLD -> outputs stable, in_ready 0; the result transfers on the cycle out_ready rises.
REQ-044 Reset after beat 2 of 3 -> out_valid never rises for that frame; the next frame's result is computed from fresh data only.
